btn_repeat: RTL and testbench
=============================

Name: btn_repeat

Overview:
- Converts debounced, synchronised button levels into discrete key events for the game controller.
- Generates a press event on each rising level and typematic auto-repeat events while a single button stays held.
- Generates a release pulse when a button drops.
- Sits directly downstream of the per-button debouncers and upstream of the game FSM; `tick` is a one-cycle enable derived from a divided clock.

Parameters:
- N_BTN, 4, number of button inputs (1..8)
- DELAY_TICKS, 500, ticks a button must be held before the first repeat (>=1)
- RATE_TICKS, 100, ticks between subsequent repeats (>=1)
- CNT_BITS, 10, tick counter width; must hold max(DELAY_TICKS, RATE_TICKS)-1

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-clk timing enable; counters advance only when high
- btn_in  in  N_BTN  debounced button levels, 1 = pressed
- press  out  N_BTN  one-clk pulse per button on new press
- rpt  out  N_BTN  one-clk pulse per button on auto-repeat
- release  out  N_BTN  one-clk pulse per button on release
- held  out  N_BTN  registered copy of btn_in
- evt_valid  out  1  one-clk pulse: any press or rpt this cycle
- evt_idx  out  $clog2(N_BTN) (min 1)  index of reported button
- evt_repeat  out  1  1 = reported event is a repeat, 0 = fresh press

Behaviour:
Reset:
- When rst is sampled high, every output goes to 0 on that edge.
- held/last-level registers go to 0, all FSMs go to IDLE, all counters go to 0.
- A button still held when rst deasserts counts as a new press: press pulses one cycle later.

Per-button FSM, evaluated each clk edge with b = btn_in[i] and m = (popcount(btn_in) > 1):
- IDLE:
  - b=1 → assert press[i] next cycle, cnt=0, go DELAY.
- DELAY:
  - b=0 → release[i], go IDLE.
  - else if tick && !m:
    - cnt==DELAY_TICKS-1 → rpt[i], cnt=0, go REPEAT.
    - else cnt++.
  - tick with m=1 → cnt holds (chord freeze).
- REPEAT:
  - b=0 → release[i], go IDLE.
  - else if tick && !m:
    - cnt==RATE_TICKS-1 → rpt[i], cnt=0.
    - else cnt++.
  - m=1 → frozen.

Latency and pulse width:
- All outputs are registered; latency is exactly 1 clk from the sampling edge.
- press, rpt, release and evt_valid are high for exactly one clk.
- Repeat cadence: DELAY_TICKS ticks to the first rpt, then one rpt every RATE_TICKS ticks.

Boundary conditions:
- DELAY_TICKS=1 or RATE_TICKS=1 → rpt on every tick in that phase.
- Release on the same edge as a terminal count → release wins; no rpt.
- A counter frozen by a chord resumes from its held value when the chord ends. No reset of the counter, no extra pulse.
- tick is ignored in IDLE.
- press and rpt never coincide for one button; a release pulse ends all activity for that button.

Event port:
- Each cycle, the lowest index i with press[i] or rpt[i] asserted drives evt_idx=i, evt_valid=1.
- evt_repeat = rpt[i] for that index.
- Events on other buttons in the same cycle appear only on the per-button vectors and are not queued.
- With no event: evt_valid=0; evt_idx and evt_repeat = 0.
- Release does not produce evt_valid.

rst mid-operation:
- Aborts all FSMs and clears all outputs on the same edge.
- Any pending repeat is discarded.

Test Plan:
(All use N_BTN=4, DELAY_TICKS=3, RATE_TICKS=2, tick=1 every clk unless stated.)
1. Short press:
   - Stimulus: btn_in=0001 for 2 clk, then 0000.
   - Required: press=0001 one clk; evt_valid=1, evt_idx=0, evt_repeat=0; release=0001 one clk after the drop; rpt never asserted.
2. Hold / auto-repeat:
   - Stimulus: btn_in=0100 held 10 clk.
   - Required: press at cycle 1; rpt=0100 at cycles 4, 6, 8, 10; evt_idx=2, evt_repeat=1 on each.
3. Tick gating:
   - Stimulus: tick high every 4th clk; hold btn 0010.
   - Required: first rpt after the 3rd tick (~12 clk), later rpts every 8 clk.
4. Simultaneous press:
   - Stimulus: btn_in 0000→1010 in one edge, held.
   - Required: press=1010; evt_idx=1; no rpt while both are held; after releasing bit 3, bit 1 repeats, resuming its frozen count.
5. Release vs terminal count:
   - Stimulus: btn 0001 dropped on the edge where cnt==DELAY_TICKS-1.
   - Required: release only; rpt=0; evt_valid=0.
6. Reset:
   - Stimulus: rst pulsed during REPEAT with btn still held.
   - Required: all outputs 0 on that edge; fresh press one clk after rst deasserts; rpt 3 ticks later.

Source files
------------

// File: rtl/btn_repeat.sv
// btn_repeat: press / typematic repeat / release event generator.
// One small FSM per button, plus a lowest-index event encoder.
module btn_repeat #(
    parameter  int N_BTN       = 4,
    parameter  int DELAY_TICKS = 500,
    parameter  int RATE_TICKS  = 100,
    parameter  int CNT_BITS    = 10,
    localparam int IDX_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] rpt,
    output logic [N_BTN-1:0] released,
    output logic [N_BTN-1:0] held,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_repeat
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    localparam logic [CNT_BITS-1:0] DLY_LAST = CNT_BITS'(DELAY_TICKS - 1);
    localparam logic [CNT_BITS-1:0] RPT_LAST = CNT_BITS'(RATE_TICKS - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    state_t              state_q [N_BTN];
    state_t              state_d [N_BTN];
    logic [CNT_BITS-1:0] cnt_q   [N_BTN];
    logic [CNT_BITS-1:0] cnt_d   [N_BTN];

    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] rpt_d;
    logic [N_BTN-1:0] rel_d;
    logic             evt_valid_d;
    logic [IDX_W-1:0] evt_idx_d;
    logic             evt_repeat_d;
    logic [3:0]       n_down;
    logic             multi;

    // Chord detect: more than one button down freezes every counter.
    always_comb begin
        n_down = '0;
        for (int i = 0; i < N_BTN; i++) begin
            n_down = n_down + {3'b000, btn_in[i]};
        end
        multi = (n_down > 4'd1);
    end

    // Per-button next state, counter and pulse generation.
    always_comb begin
        press_d = '0;
        rpt_d   = '0;
        rel_d   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (btn_in[i]) begin
                        press_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                        state_d[i] = DELAY;
                    end
                end
                DELAY: begin
                    if (!btn_in[i]) begin
                        rel_d[i]   = 1'b1;
                        state_d[i] = IDLE;
                    end else if (tick && !multi) begin
                        if (cnt_q[i] == DLY_LAST) begin
                            rpt_d[i]   = 1'b1;
                            cnt_d[i]   = '0;
                            state_d[i] = REPEAT;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                end
                REPEAT: begin
                    if (!btn_in[i]) begin
                        rel_d[i]   = 1'b1;
                        state_d[i] = IDLE;
                    end else if (tick && !multi) begin
                        if (cnt_q[i] == RPT_LAST) begin
                            rpt_d[i] = 1'b1;
                            cnt_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Event encoder: lowest index with a press or repeat wins.
    always_comb begin
        evt_valid_d  = 1'b0;
        evt_idx_d    = '0;
        evt_repeat_d = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_d[i] || rpt_d[i]) begin
                evt_valid_d  = 1'b1;
                evt_idx_d    = IDX_W'(i);
                evt_repeat_d = rpt_d[i];
            end
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            press      <= '0;
            rpt        <= '0;
            released   <= '0;
            held       <= '0;
            evt_valid  <= 1'b0;
            evt_idx    <= '0;
            evt_repeat <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            press      <= press_d;
            rpt        <= rpt_d;
            released   <= rel_d;
            held       <= btn_in;
            evt_valid  <= evt_valid_d;
            evt_idx    <= evt_idx_d;
            evt_repeat <= evt_repeat_d;
        end
    end

endmodule

// File: tb/tb_btn_repeat.sv
// tb_btn_repeat: directed stimulus with a per-edge expectation queue.
// The monitor compares every cycle; edges with no entry expect silence.
module tb_btn_repeat;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic [3:0] btn_in = '0;
    logic [3:0] press;
    logic [3:0] rpt;
    logic [3:0] released;
    logic [3:0] held;
    logic       evt_valid;
    logic [1:0] evt_idx;
    logic       evt_repeat;

    btn_repeat #(
        .N_BTN      (4),
        .DELAY_TICKS(3),
        .RATE_TICKS (2),
        .CNT_BITS   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn_in    (btn_in),
        .press     (press),
        .rpt       (rpt),
        .released  (released),
        .held      (held),
        .evt_valid (evt_valid),
        .evt_idx   (evt_idx),
        .evt_repeat(evt_repeat)
    );

    typedef struct {
        int         e;
        logic [3:0] p;
        logic [3:0] r;
        logic [3:0] l;
        logic       v;
        logic [1:0] idx;
        logic       rep;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    int         edge_n = 0;
    int         tick_period = 1;
    int         checks = 0;
    int         passes = 0;
    bit         mon_on = 1'b0;
    logic [3:0] s_btn = '0;
    logic       s_rst = 1'b1;
    logic [3:0] exp_h;

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        s_btn  <= btn_in;
        s_rst  <= rst;
    end

    // tick is high at edges whose number is a multiple of tick_period
    always @(posedge clk) begin
        #1;
        tick = ((edge_n + 1) % tick_period) == 0;
    end

    function automatic void ex(input int e, input logic [3:0] p,
                               input logic [3:0] r, input logic [3:0] l,
                               input logic v, input logic [1:0] idx,
                               input logic rep);
        exp_t x;
        x.e = e; x.p = p; x.r = r; x.l = l;
        x.v = v; x.idx = idx; x.rep = rep;
        q.push_back(x);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            cur.e = edge_n; cur.p = '0; cur.r = '0; cur.l = '0;
            cur.v = 1'b0; cur.idx = '0; cur.rep = 1'b0;
            if (q.size() > 0 && q[0].e == edge_n) cur = q.pop_front();
            exp_h = s_rst ? 4'b0000 : s_btn;
            checks++;
            if ({press, rpt, released} === {cur.p, cur.r, cur.l}) passes++;
            else $display("FAIL pulses edge %0d: got p=%b r=%b l=%b want p=%b r=%b l=%b",
                          edge_n, press, rpt, released, cur.p, cur.r, cur.l);
            checks++;
            if ({evt_valid, evt_idx, evt_repeat} === {cur.v, cur.idx, cur.rep}) passes++;
            else $display("FAIL event edge %0d: got v=%b i=%0d r=%b want v=%b i=%0d r=%b",
                          edge_n, evt_valid, evt_idx, evt_repeat, cur.v, cur.idx, cur.rep);
            checks++;
            if (held === exp_h) passes++;
            else $display("FAIL held edge %0d: got %b want %b", edge_n, held, exp_h);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        @(posedge clk);
        #2;
        mon_on = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);

        // 1: short press
        b = edge_n; btn_in = 4'b0001;
        ex(b + 1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0);
        ex(b + 3, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);
        step(2); btn_in = 4'b0000; step(3);

        // 2: hold with auto-repeat
        b = edge_n; btn_in = 4'b0100;
        ex(b + 1, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0);
        for (int k = 4; k <= 10; k += 2)
            ex(b + k, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b1);
        ex(b + 11, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b0);
        step(10); btn_in = 4'b0000; step(3);

        // 3: tick every 4th clock, first tick on the press edge
        tick_period = 4;
        step(1);
        for (int k = 0; k < 4 && (edge_n % 4) != 3; k++) step(1);
        b = edge_n; btn_in = 4'b0010;
        ex(b + 1,  4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0);
        ex(b + 13, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1);
        ex(b + 21, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1);
        ex(b + 24, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0);
        step(23); btn_in = 4'b0000; tick_period = 1; step(3);

        // 4a: simultaneous press, chord freezes at zero
        b = edge_n; btn_in = 4'b1010;
        ex(b + 1, 4'b1010, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0);
        ex(b + 5, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b0);
        ex(b + 7, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1);
        ex(b + 8, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0);
        step(4); btn_in = 4'b0010;
        step(3); btn_in = 4'b0000; step(3);

        // 4b: chord freezes a nonzero count, which resumes
        b = edge_n; btn_in = 4'b0010;
        ex(b + 1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0);
        ex(b + 3, 4'b1000, 4'b0000, 4'b0000, 1'b1, 2'd3, 1'b0);
        ex(b + 6, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b0);
        ex(b + 7, 4'b0000, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b1);
        ex(b + 8, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0);
        step(2); btn_in = 4'b1010;
        step(3); btn_in = 4'b0010;
        step(2); btn_in = 4'b0000; step(3);

        // 5: release on the terminal-count edge
        b = edge_n; btn_in = 4'b0001;
        ex(b + 1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0);
        ex(b + 4, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);
        step(3); btn_in = 4'b0000; step(3);

        // 6: reset during REPEAT with button held
        b = edge_n; btn_in = 4'b0001;
        ex(b + 1,  4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0);
        ex(b + 4,  4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1);
        ex(b + 7,  4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0);
        ex(b + 10, 4'b0000, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1);
        ex(b + 11, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);
        step(5); rst = 1'b1;
        step(1); rst = 1'b0;
        step(4); btn_in = 4'b0000; step(3);

        mon_on = 1'b0;
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL leftover: got %0d unmatched expectations want 0", q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
